// File: rtl/preload_sequencer_pkg.sv
// Shared definitions for the weight/activation preload sequencer and the TPU top.
package preload_sequencer_pkg;

  localparam int N_BEATS_DEFAULT        = 64;
  localparam int PRELOAD_CYCLES_DEFAULT = 8;
  localparam int CAL_CYCLES_DEFAULT     = 24;

  localparam int ADDR_W   = 6;
  localparam int WEIGHT_W = 8;
  localparam int ACT_W    = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PRELOAD = 3'd2,
    ST_CAL     = 3'd3,
    ST_FINISH  = 3'd4
  } seq_state_e;

  // Width of the shared phase timer: it must hold the longer phase length minus one.
  function automatic int phase_cnt_width(input int preload_len, input int cal_len);
    int max_len;
    max_len = (preload_len > cal_len) ? preload_len : cal_len;
    return (max_len > 2) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/preload_sequencer_phase_counter.sv
// Loadable down-counter with a zero flag; times the preload and compute phases.
module phase_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/preload_sequencer.sv
// Tile sequencer: loads N_BEATS weight/activation beats into the pre-load unit,
// then runs the compensation-weight preload phase and the compute phase.
module preload_sequencer
  import preload_sequencer_pkg::*;
#(
  parameter int N_BEATS        = N_BEATS_DEFAULT,
  parameter int PRELOAD_CYCLES = PRELOAD_CYCLES_DEFAULT,
  parameter int CAL_CYCLES     = CAL_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WEIGHT_W-1:0] in_weight,
  input  logic [ACT_W-1:0]    in_act,
  output logic [WEIGHT_W-1:0] Weight,
  output logic [ADDR_W-1:0]   Weight_Mem_Address_in,
  output logic [ACT_W-1:0]    Activation,
  output logic [ADDR_W-1:0]   Activation_Mem_Address_in,
  output logic                load_mem_done,
  output logic                PreLoad_CWeight,
  output logic                Cal,
  output logic                busy,
  output logic                done
);

  localparam int                CNT_W        = phase_cnt_width(PRELOAD_CYCLES, CAL_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_BEAT    = ADDR_W'(N_BEATS - 1);
  localparam logic [CNT_W-1:0]  PRELOAD_LOAD = CNT_W'(PRELOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CAL_LOAD     = CNT_W'(CAL_CYCLES - 1);

  seq_state_e          state_q, state_d;
  logic                pre_entry_q, pre_entry_d;
  logic [ADDR_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WEIGHT_W-1:0] weight_q, weight_d;
  logic [ACT_W-1:0]    act_q, act_d;
  logic                load_done_q, load_done_d;

  logic                accept;
  logic                last_beat;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_zero;
  logic [CNT_W-1:0]    cnt_val;

  assign in_ready  = (state_q == ST_LOAD);
  assign accept    = in_ready && in_valid;
  assign last_beat = accept && (beat_q == LAST_BEAT);

  // The first PRELOAD cycle only publishes load_mem_done and arms the timer,
  // so PreLoad_CWeight starts one cycle after load_mem_done rises.
  always_comb begin
    state_d         = state_q;
    pre_entry_d     = 1'b0;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    cnt_val         = '0;
    busy            = (state_q != ST_IDLE);
    done            = 1'b0;
    PreLoad_CWeight = 1'b0;
    Cal             = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_beat) begin
          state_d     = ST_PRELOAD;
          pre_entry_d = 1'b1;
        end
      end
      ST_PRELOAD: begin
        PreLoad_CWeight = !pre_entry_q;
        if (pre_entry_q) begin
          cnt_load = 1'b1;
          cnt_val  = PRELOAD_LOAD;
        end else if (cnt_zero) begin
          state_d  = ST_CAL;
          cnt_load = 1'b1;
          cnt_val  = CAL_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_CAL: begin
        Cal = 1'b1;
        if (cnt_zero) begin
          state_d = ST_FINISH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered output stage: beat data and its index appear the cycle after acceptance.
  always_comb begin
    beat_d      = beat_q;
    addr_d      = addr_q;
    weight_d    = weight_q;
    act_d       = act_q;
    load_done_d = load_done_q;
    if ((state_q == ST_IDLE) && start) begin
      beat_d      = '0;
      load_done_d = 1'b0;
    end
    if (accept) begin
      weight_d = in_weight;
      act_d    = in_act;
      addr_d   = beat_q;
      if (!last_beat) begin
        beat_d = beat_q + 1'b1;
      end
    end
    if (last_beat) begin
      load_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pre_entry_q <= 1'b0;
      beat_q      <= '0;
      addr_q      <= '0;
      weight_q    <= '0;
      act_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_entry_q <= pre_entry_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      weight_q    <= weight_d;
      act_q       <= act_d;
      load_done_q <= load_done_d;
    end
  end

  phase_counter #(
    .W(CNT_W)
  ) u_phase_counter (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  assign Weight                    = weight_q;
  assign Activation                = act_q;
  assign Weight_Mem_Address_in     = addr_q;
  assign Activation_Mem_Address_in = addr_q;
  assign load_mem_done             = load_done_q;

endmodule

// File: tb/tb_preload_sequencer.sv
// Self-checking bench: directed tile sequences with random data/valid gaps,
// compared every cycle against a phase-timing reference model.
module tb_preload_sequencer;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_weight = '0;
  logic [6:0] in_act = '0;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  logic       rdy0, lmd0, pre0, cal0, busy0, done0;
  logic [7:0] w0;
  logic [6:0] a0;
  logic [5:0] wa0, aa0;
  logic       rdy1, lmd1, pre1, cal1, busy1, done1;
  logic [7:0] w1;
  logic [6:0] a1;
  logic [5:0] wa1, aa1;

  preload_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .in_weight(in_weight), .in_act(in_act), .Weight(w0), .Weight_Mem_Address_in(wa0),
    .Activation(a0), .Activation_Mem_Address_in(aa0), .load_mem_done(lmd0),
    .PreLoad_CWeight(pre0), .Cal(cal0), .busy(busy0), .done(done0)
  );

  preload_sequencer #(.PRELOAD_CYCLES(1), .CAL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .in_weight(in_weight), .in_act(in_act), .Weight(w1), .Weight_Mem_Address_in(wa1),
    .Activation(a1), .Activation_Mem_Address_in(aa1), .load_mem_done(lmd1),
    .PreLoad_CWeight(pre1), .Cal(cal1), .busy(busy1), .done(done1)
  );

  logic       o_rdy, o_lmd, o_pre, o_cal, o_busy, o_done;
  logic [7:0] o_w;
  logic [6:0] o_a;
  logic [5:0] o_wa, o_aa;

  assign o_rdy  = sel ? rdy1  : rdy0;
  assign o_lmd  = sel ? lmd1  : lmd0;
  assign o_pre  = sel ? pre1  : pre0;
  assign o_cal  = sel ? cal1  : cal0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_w    = sel ? w1    : w0;
  assign o_a    = sel ? a1    : a0;
  assign o_wa   = sel ? wa1   : wa0;
  assign o_aa   = sel ? aa1   : aa0;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: beats accepted so far, and cycles elapsed since load_mem_done rose.
  int         m_k, m_post, m_P, m_C;
  bit         m_loading;
  logic [7:0] m_w;
  logic [6:0] m_a;
  logic [5:0] m_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_k       = 0;
    m_post    = -1;
    m_w       = '0;
    m_a       = '0;
    m_addr    = '0;
  endtask

  task automatic check_all();
    bit b;
    b = m_loading || (m_post >= 0 && m_post <= m_P + m_C + 1);
    $display("t=%0t k=%0d post=%0d rdy=%0b busy=%0b lmd=%0b pre=%0b cal=%0b done=%0b w=%0h a=%0h addr=%0d",
             $time, m_k, m_post, o_rdy, o_busy, o_lmd, o_pre, o_cal, o_done, o_w, o_a, o_wa);
    chk("in_ready", 32'(o_rdy), 32'(m_loading));
    chk("busy", 32'(o_busy), 32'(b));
    chk("load_mem_done", 32'(o_lmd), 32'(m_post >= 0));
    chk("PreLoad_CWeight", 32'(o_pre), 32'(m_post >= 1 && m_post <= m_P));
    chk("Cal", 32'(o_cal), 32'(m_post > m_P && m_post <= m_P + m_C));
    chk("done", 32'(o_done), 32'(m_post == m_P + m_C + 1));
    chk("Weight", 32'(o_w), 32'(m_w));
    chk("Activation", 32'(o_a), 32'(m_a));
    chk("Weight_addr", 32'(o_wa), 32'(m_addr));
    chk("Activation_addr", 32'(o_aa), 32'(m_addr));
  endtask

  task automatic pulse_reset();
    start = 1'b0;
    rst   = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_all();
    end
  endtask

  // mode 0: valid every cycle, beat k carries k; 1: valid on even cycles; 2: random gaps.
  task automatic run_tile(input int mode, input bit ext_start, input bit chain,
                          input int abort_post, input bit check_total);
    int         cyc;
    bit         v;
    logic [7:0] wt;
    logic [6:0] ac;
    start = 1'b1;
    @(posedge clk); #1;
    m_loading = 1'b1;
    m_k       = 0;
    m_post    = -1;
    cyc       = 1;
    start     = 1'b0;
    for (int it = 0; it < 4000; it++) begin
      check_all();
      if (abort_post >= 0 && m_post == abort_post) begin
        pulse_reset();
        return;
      end
      if (m_post == m_P + m_C + 1) begin
        if (check_total) chk("start_to_done", 32'(cyc), 32'(1 + N + m_P + m_C + 1));
        start    = chain;
        in_valid = 1'b0;
        @(posedge clk); #1;
        m_post++;
        check_all();
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 0) begin
        wt = 8'(m_k);
        ac = 7'(m_k);
      end else begin
        wt = 8'($urandom);
        ac = 7'($urandom);
      end
      in_valid  = v;
      in_weight = wt;
      in_act    = ac;
      start     = ext_start && ((m_loading && m_k == 10) || (m_post == m_P + 2));
      @(posedge clk); #1;
      cyc++;
      if (m_loading && v) begin
        m_w    = wt;
        m_a    = ac;
        m_addr = 6'(m_k);
        m_k++;
        if (m_k == N) begin
          m_loading = 1'b0;
          m_post    = 0;
        end
      end else if (m_post >= 0) begin
        m_post++;
      end
    end
    n_assert++;
    n_fail++;
    $error("FAIL tile_timeout: observed=no_done expected=done");
  endtask

  initial begin
    m_P = 8;
    m_C = 24;
    model_reset();
    #1 rst = 1'b0;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    @(posedge clk); #1;
    check_all();

    run_tile(0, 1'b0, 1'b0, -1, 1'b1);
    run_tile(1, 1'b0, 1'b0, -1, 1'b0);
    run_tile(0, 1'b1, 1'b0, -1, 1'b1);
    run_tile(2, 1'b0, 1'b1, -1, 1'b0);
    run_tile(0, 1'b0, 1'b0, -1, 1'b1);
    run_tile(2, 1'b0, 1'b0, m_P + 5, 1'b0);

    rst = 1'b0;
    #1;
    sel = 1'b1;
    m_P = 1;
    m_C = 1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all();
    run_tile(2, 1'b0, 1'b1, -1, 1'b0);
    run_tile(0, 1'b0, 1'b1, -1, 1'b1);
    run_tile(2, 1'b0, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/preload_sequencer.md
PRELOAD_SEQUENCER -- requirements
Module: preload_sequencer

Interface
REQ-001 Parameter N_BEATS, default 64, number of weight/activation pairs per tile (8x8 array).
REQ-002 Parameter PRELOAD_CYCLES, default 8, cycles PreLoad_CWeight is held high.
REQ-003 Parameter CAL_CYCLES, default 24, cycles Cal is held high.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin one tile sequence; sampled only in IDLE.
REQ-007 in_valid  input  1  upstream beat valid.
REQ-008 in_ready  output  1  sequencer accepts a beat this cycle.
REQ-009 in_weight  input  8  weight byte of current beat.
REQ-010 in_act  input  7  activation of current beat.
REQ-011 Weight  output  8  registered weight to the pre-load unit.
REQ-012 Weight_Mem_Address_in  output  6  registered weight write address.
REQ-013 Activation  output  7  registered activation to the pre-load unit.
REQ-014 Activation_Mem_Address_in  output  6  registered activation write address.
REQ-015 load_mem_done  output  1  all N_BEATS loaded; level.
REQ-016 PreLoad_CWeight  output  1  compensation-weight preload phase.
REQ-017 Cal  output  1  compute phase.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 done  output  1  one-cycle pulse at sequence end.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, PRELOAD, CAL, FINISH.
REQ-021 IDLE -> LOAD when start=1; start in any other state SHALL be ignored.
REQ-022 in_ready SHALL equal 1 exactly while state is LOAD, combinationally from state.
REQ-023 A beat is accepted on a cycle with in_valid && in_ready; the next cycle Weight/Activation SHALL show that beat's data and both addresses SHALL equal the beat index (0..N_BEATS-1).
REQ-024 When in_valid=0 during LOAD, data and address outputs SHALL hold their previous values; the beat index SHALL not advance.
REQ-025 Beat index SHALL be a 6-bit counter cleared on IDLE->LOAD; it SHALL not wrap within a tile.
REQ-026 On acceptance of beat N_BEATS-1, state SHALL go LOAD -> PRELOAD; load_mem_done SHALL rise the following cycle (same cycle last data appears on outputs) and stay high until the next IDLE->LOAD transition.
REQ-027 PreLoad_CWeight SHALL be high for exactly PRELOAD_CYCLES consecutive cycles, starting the cycle after load_mem_done rises.
REQ-028 Cal SHALL rise the cycle after PreLoad_CWeight falls and stay high exactly CAL_CYCLES cycles; PreLoad_CWeight and Cal SHALL never be high together.
REQ-029 After CAL, FINISH lasts one cycle with done=1, then IDLE; busy SHALL fall on entry to IDLE.
REQ-030 start asserted in the same cycle as done SHALL be ignored; start in the first IDLE cycle SHALL be accepted.
REQ-031 Phase lengths SHALL be timed by one down-counter loaded with length-1 on phase entry; transition on count 0.

Reset
REQ-032 While rst=0 all outputs SHALL be 0 (addresses 0, data 0, load_mem_done 0, in_ready 0, busy 0, done 0) and state SHALL be IDLE, independent of clk.
REQ-033 Reset asserted mid-LOAD/PRELOAD/CAL SHALL abort the tile; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-034 State encoding, N_BEATS and default phase lengths SHALL live in a shared package used by the TPU top.
REQ-035 The phase timer SHALL be a sub-module phase_counter (load, decrement, zero flag, async active-low reset).
REQ-036 Total RTL SHALL be a single FSM plus registered output stage; no memories inside.

Verification
REQ-037 Reset mid-CAL: drop rst for 1 cycle -> all outputs 0 immediately, IDLE, busy=0, no done pulse.
REQ-038 Full tile, in_valid always 1, beat k = weight k, act k&7F -> addresses 0..63 in order, load_mem_done rises 1 cycle after beat 63 accepted, PreLoad_CWeight high 8 cycles, Cal high 24 cycles, done pulses once; total start-to-done 1+64+8+24+1 cycles.
REQ-039 in_valid gaps (valid only on even cycles) -> 64 distinct addresses, outputs hold during gaps, no skipped or repeated index.
REQ-040 start pulses during LOAD and CAL -> no restart, sequence timing identical to REQ-038.
REQ-041 start asserted in done cycle then in next cycle -> only second start begins a tile; load_mem_done drops on that IDLE->LOAD.
REQ-042 Back-to-back tiles with PRELOAD_CYCLES=1, CAL_CYCLES=1 -> each phase exactly one cycle, no overlap of PreLoad_CWeight and Cal.
